// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - IR/memory handshake and datapath control bundle for the multicycle MIPS controller
interface mips_multicycle_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        illegal;
    logic [3:0]  state;

    modport master (
        input  instr, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal, state
    );

    modport slave (
        output instr, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
               alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM; PERF_COUNT_EN adds cycle/retired counters
module mips_multicycle_ctrl (
    input  logic clk,
    input  logic rst,
    mips_multicycle_ctrl_if.master bus
`ifdef PERF_COUNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       illegal_q;
    logic [5:0] opcode, funct;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       unused_instr;

    assign opcode       = bus.instr[31:26];
    assign funct        = bus.instr[5:0];
    assign unused_instr = ^bus.instr[25:6];
    assign bus.state    = state_q;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_src        = 2'b00;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_ctrl      = ALU_ADD;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.illegal       = illegal_q;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch target PC + (imm<<2) lands in ALUOut for BRANCH
                bus.alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = funct_alu;
                state_d       = funct_ok ? S_ALUWB : S_ILLEGAL;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_ctrl      = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
                state_d           = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
                state_d      = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase

        // Reset masks every control so a half-finished instruction cannot write anything
        if (!rst) begin
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.iord          = 1'b0;
            bus.ir_write      = 1'b0;
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.pc_src        = 2'b00;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = 2'b00;
            bus.alu_ctrl      = ALU_ADD;
            bus.reg_write     = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.illegal       = 1'b0;
        end
    end

`ifdef PERF_COUNT_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = (state_d != state_q);
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_cnt   <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - vector table, corner sequences and randomized model check of mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus();

`ifdef PERF_COUNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
    int m_cyc = 0;
    always @(posedge clk) begin
        if (!rst) m_cyc <= 0;
        else      m_cyc <= m_cyc + 1;
    end
`endif

    mips_multicycle_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef PERF_COUNT_EN
        ,
        .cycle_cnt(cycle_cnt),
        .retired_cnt(retired_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int m_ret = 0;

    typedef struct {
        logic [31:0] instr;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] exp;
    } row_t;
    row_t rows[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Field order: mem_read mem_write iord ir_write pc_write pc_write_cond pc_src
    //              alu_src_a alu_src_b alu_ctrl reg_write reg_dst mem_to_reg illegal
    function automatic logic [17:0] act_outs();
        return {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};
    endfunction

    function automatic logic [17:0] mask_of(input logic [3:0] st);
        logic [17:0] m;
        m = '0;
        m[17] = 1'b1; m[16] = 1'b1; m[14] = 1'b1; m[13] = 1'b1; m[12] = 1'b1;
        m[3] = 1'b1; m[0] = 1'b1;
        case (st)
            4'd0: begin m[15] = 1'b1; m[11:10] = '1; m[9] = 1'b1; m[8:7] = '1; m[6:4] = '1; end
            4'd1, 4'd2, 4'd6, 4'd9: begin m[9] = 1'b1; m[8:7] = '1; m[6:4] = '1; end
            4'd3, 4'd5: m[15] = 1'b1;
            4'd4, 4'd7, 4'd10: begin m[2] = 1'b1; m[1] = 1'b1; end
            4'd8: begin m[11:10] = '1; m[9] = 1'b1; m[8:7] = '1; m[6:4] = '1; end
            4'd11: m[11:10] = '1;
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    localparam logic [17:0] F1  = 18'b1_0_0_1_1_0_00_0_01_010_0_0_0_0;
    localparam logic [17:0] F0  = 18'b1_0_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [17:0] DEC = 18'b0_0_0_0_0_0_00_0_11_010_0_0_0_0;
    localparam logic [17:0] MA  = 18'b0_0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [17:0] MRD = 18'b1_0_1_0_0_0_00_0_00_000_0_0_0_0;
    localparam logic [17:0] MWR = 18'b0_1_1_0_0_0_00_0_00_000_0_0_0_0;
    localparam logic [17:0] MWB = 18'b0_0_0_0_0_0_00_0_00_000_1_0_1_0;
    localparam logic [17:0] AWB = 18'b0_0_0_0_0_0_00_0_00_000_1_1_0_0;
    localparam logic [17:0] IWB = 18'b0_0_0_0_0_0_00_0_00_000_1_0_0_0;
    localparam logic [17:0] BR  = 18'b0_0_0_0_0_1_01_1_00_110_0_0_0_0;
    localparam logic [17:0] JMP = 18'b0_0_0_0_1_0_10_0_00_000_0_0_0_0;
    localparam logic [17:0] EXB = 18'b0_0_0_0_0_0_00_1_00_000_0_0_0_0;
    localparam logic [17:0] RST = 18'b0_0_0_0_0_0_00_0_00_010_0_0_0_0;
    localparam logic [17:0] ILL = 18'b0_0_0_0_0_0_00_0_00_000_0_0_0_1;

    task automatic add_row(input logic [31:0] ins, input logic mr, input logic [3:0] st,
                           input logic [17:0] exp);
        row_t r;
        r.instr = ins; r.mr = mr; r.st = st; r.exp = exp;
        rows.push_back(r);
    endtask

    // Entered and left aligned to a falling edge; the FETCH cycle follows immediately.
    task automatic do_reset();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_ret = 0;
    endtask

    task automatic run_cycle(input string tag, input logic [31:0] ins, input logic mr,
                             input logic [3:0] st, input logic [17:0] exp);
        logic [17:0] m;
        m = mask_of(st);
        bus.instr = ins;
        bus.mem_ready = mr;
        #1;
        chk({tag, "_state"}, bus.state, st);
        chk({tag, "_outs"}, act_outs() & m, exp & m);
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [5:0] fns [5];
        logic [31:0] ins;
        logic [3:0] path[$];
        int cls, idx, cyc;
        logic mr;
        logic [3:0] es;

        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int i = 0; i < 5; i++) begin
            ins = 32'h00431000 | {26'd0, fns[i]};
            add_row(ins, 1'b1, 4'd0, F1);
            add_row(ins, 1'b0, 4'd1, DEC);
            add_row(ins, 1'b0, 4'd6, EXB | {11'd0, alu_of(fns[i]), 4'd0});
            add_row(ins, 1'b1, 4'd7, AWB);
        end
        add_row(32'h20420002, 1'b1, 4'd0, F1);
        add_row(32'h20420002, 1'b1, 4'd1, DEC);
        add_row(32'h20420002, 1'b1, 4'd9, MA);
        add_row(32'h20420002, 1'b1, 4'd10, IWB);
        add_row(32'h8C620004, 1'b1, 4'd0, F1);
        add_row(32'h8C620004, 1'b1, 4'd1, DEC);
        add_row(32'h8C620004, 1'b1, 4'd2, MA);
        add_row(32'h8C620004, 1'b0, 4'd3, MRD);
        add_row(32'h8C620004, 1'b0, 4'd3, MRD);
        add_row(32'h8C620004, 1'b1, 4'd3, MRD);
        add_row(32'h8C620004, 1'b1, 4'd4, MWB);
        add_row(32'hAC620004, 1'b0, 4'd0, F0);
        add_row(32'hAC620004, 1'b1, 4'd0, F1);
        add_row(32'hAC620004, 1'b1, 4'd1, DEC);
        add_row(32'hAC620004, 1'b1, 4'd2, MA);
        add_row(32'hAC620004, 1'b0, 4'd5, MWR);
        add_row(32'hAC620004, 1'b1, 4'd5, MWR);
        add_row(32'h10430003, 1'b1, 4'd0, F1);
        add_row(32'h10430003, 1'b1, 4'd1, DEC);
        add_row(32'h10430003, 1'b0, 4'd8, BR);
        add_row(32'h08000010, 1'b1, 4'd0, F1);
        add_row(32'h08000010, 1'b1, 4'd1, DEC);
        add_row(32'h08000010, 1'b1, 4'd11, JMP);
        add_row(32'h08000010, 1'b1, 4'd0, F1);

        bus.instr = 32'h0;
        bus.mem_ready = 1'b1;
        @(negedge clk);

        // Reset outputs and first FETCH after release
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("reset_outs", act_outs(), RST);
            chk("reset_state", bus.state, 4'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_state", bus.state, 4'd0);
        chk("release_mem_read", bus.mem_read, 1'b1);
        chk("release_ir_write", bus.ir_write, 1'b1);
        @(negedge clk);

        do_reset();
        foreach (rows[i]) run_cycle("vec", rows[i].instr, rows[i].mr, rows[i].st, rows[i].exp);

        // Bad funct: terminal ILLEGAL, cleared only by reset
        do_reset();
        run_cycle("badfn", 32'h00431021, 1'b1, 4'd0, F1);
        run_cycle("badfn", 32'h00431021, 1'b1, 4'd1, DEC);
        bus.instr = 32'h00431021;
        #1;
        chk("badfn_exec_state", bus.state, 4'd6);
        @(negedge clk);
        for (int i = 0; i < 10; i++) run_cycle("illegal", 32'h00431021, i[0], 4'd12, ILL);
`ifdef PERF_COUNT_EN
        #1;
        chk("illegal_retired", retired_cnt, 32'd0);
        chk("illegal_cycles", cycle_cnt, m_cyc);
        chk("illegal_cycles_value", cycle_cnt, 32'd13);
        @(negedge clk);
`endif
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("illegal_cleared", bus.illegal, 1'b0);
        @(negedge clk);

        // Unsupported opcode goes straight from DECODE to ILLEGAL
        do_reset();
        run_cycle("badop", 32'hFC000000, 1'b1, 4'd0, F1);
        run_cycle("badop", 32'hFC000000, 1'b1, 4'd1, DEC);
        run_cycle("badop", 32'hFC000000, 1'b1, 4'd12, ILL);

        // Reset while a store is waiting on memory drops the store
        do_reset();
        run_cycle("midrst", 32'hAC620004, 1'b1, 4'd0, F1);
        run_cycle("midrst", 32'hAC620004, 1'b1, 4'd1, DEC);
        run_cycle("midrst", 32'hAC620004, 1'b1, 4'd2, MA);
        run_cycle("midrst", 32'hAC620004, 1'b0, 4'd5, MWR);
        rst = 1'b0;
        #1;
        chk("midrst_outs", act_outs(), RST);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_state", bus.state, 4'd0);
        chk("midrst_no_write", bus.mem_write, 1'b0);
        @(negedge clk);

        // Random instruction stream against a path-list model
        do_reset();
        for (int k = 0; k < 150; k++) begin
            cls = $urandom_range(0, 9);
            path.delete();
            case (cls)
                0, 1, 2, 3, 4: begin
                    ins = {6'h00, 20'($urandom), fns[cls]};
                    path = '{4'd0, 4'd1, 4'd6, 4'd7};
                end
                5: begin ins = {6'h08, 26'($urandom)}; path = '{4'd0, 4'd1, 4'd9, 4'd10}; end
                6: begin ins = {6'h23, 26'($urandom)}; path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4}; end
                7: begin ins = {6'h2B, 26'($urandom)}; path = '{4'd0, 4'd1, 4'd2, 4'd5}; end
                8: begin ins = {6'h04, 26'($urandom)}; path = '{4'd0, 4'd1, 4'd8}; end
                default: begin ins = {6'h02, 26'($urandom)}; path = '{4'd0, 4'd1, 4'd11}; end
            endcase
            idx = 0;
            cyc = 0;
            while (idx < path.size()) begin
                mr = ($urandom_range(0, 3) != 0);
                bus.instr = ins;
                bus.mem_ready = mr;
                #1;
                es = path[idx];
                chk("rnd_state", bus.state, es);
                chk("rnd_mem_read", bus.mem_read, (es == 4'd0 || es == 4'd3));
                chk("rnd_mem_write", bus.mem_write, (es == 4'd5));
                chk("rnd_reg_write", bus.reg_write, (es == 4'd4 || es == 4'd7 || es == 4'd10));
                chk("rnd_ir_write", bus.ir_write, (es == 4'd0 && mr));
                if (es == 4'd6) chk("rnd_alu_ctrl", bus.alu_ctrl, alu_of(ins[5:0]));
                if (!((es == 4'd0 || es == 4'd3 || es == 4'd5) && !mr)) idx++;
                if (idx == path.size()) m_ret++;
                @(negedge clk);
                cyc++;
                if (cyc > 200) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rnd_bound: instruction %0h exceeded 200 cycles", ins);
                    break;
                end
            end
        end
`ifdef PERF_COUNT_EN
        #1;
        chk("rnd_retired", retired_cnt, m_ret);
        chk("rnd_cycles", cycle_cnt, m_cyc);
`endif
        chk("rnd_illegal_clear", bus.illegal, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
